// File: rtl/hazard_ctrl_pkg.sv
// Shared processor definitions for the hazard controller.
// Contents:
//   state_e      - hazard controller FSM encoding (RUN, DRAIN, HALTED)
//   sb_entry_t   - one scoreboard slot {valid, dest}
//   DRAIN_CYCLES - cycles needed for the instructions behind HALT to retire
package hazard_ctrl_pkg;

  localparam int REG_W = 3;
  localparam int CNT_W = 16;

  // HALT enters EX on the cycle after issue; EX, MEM and WB then need
  // three cycles before the pipeline holds nothing live.
  localparam logic [1:0] DRAIN_CYCLES = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Two-slot destination scoreboard tracking the EX and MEM stages.
// WB is not tracked: the register file writes in the first half of the
// cycle, so a WB-stage producer is already visible to the ID read.
// Ports:
//   clk, rst               - clock, asynchronous active-low reset
//   shift_valid/shift_dest - entry entering EX this cycle
//   q_rs, q_rt             - registers being read in ID
//   match_rs, match_rt     - query register is pending in EX or MEM
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_valid,
  input  logic [REG_W-1:0] shift_dest,
  input  logic [REG_W-1:0] q_rs,
  input  logic [REG_W-1:0] q_rt,
  output logic             match_rs,
  output logic             match_rt
);

  sb_entry_t ex_q, ex_d;
  sb_entry_t mem_q, mem_d;

  always_comb begin
    ex_d.valid = shift_valid;
    ex_d.dest  = shift_dest;
    mem_d      = ex_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
    end
  end

  assign match_rs = (ex_q.valid  && (ex_q.dest  == q_rs)) ||
                    (mem_q.valid && (mem_q.dest == q_rs));
  assign match_rt = (ex_q.valid  && (ex_q.dest  == q_rt)) ||
                    (mem_q.valid && (mem_q.dest == q_rt));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW interlock against EX/MEM producers,
// branch-redirect squash and HALT drain sequencing.
// Ports:
//   clk, rst      - clock, asynchronous active-low reset
//   id_*          - decode-stage instruction fields
//   ex_redirect   - taken branch/jump resolved in EX
//   pc_stall      - hold PC
//   ifid_stall    - hold IF/ID
//   idex_bubble   - load NOP into ID/EX
//   ifid_flush    - squash IF/ID
//   halted        - pipeline drained after HALT (registered)
//   stall_cnt     - saturating count of RAW stall cycles (registered)
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_rs_used,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrt,
  input  logic             id_halt,
  input  logic             ex_redirect,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e           state_q, state_d;
  logic [1:0]       drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic match_rs, match_rt;
  logic in_run, raw, issue, raw_stall, redirect_act, hold;

  assign in_run = (state_q == ST_RUN);
  assign raw    = id_valid & ((id_rs_used & match_rs) | (id_rt_used & match_rt));
  assign issue  = id_valid & ~raw & ~ex_redirect & in_run;

  // Redirect wins over a RAW stall; both only matter while running.
  assign redirect_act = in_run & ex_redirect;
  assign raw_stall    = in_run & raw & ~ex_redirect;
  assign hold         = ~in_run | raw_stall;

  hazard_scoreboard u_sb (
    .clk         (clk),
    .rst         (rst),
    .shift_valid (id_valid & id_regwrt & issue),
    .shift_dest  (id_rd),
    .q_rs        (id_rs),
    .q_rt        (id_rt),
    .match_rs    (match_rs),
    .match_rt    (match_rt)
  );

  // Gated by rst so an ex_redirect seen during reset cannot flush.
  assign pc_stall    = rst & hold;
  assign ifid_stall  = rst & hold;
  assign idex_bubble = rst & (hold | redirect_act);
  assign ifid_flush  = rst & redirect_act;

  assign halted    = (state_q == ST_HALTED);
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      ST_RUN: begin
        if (issue && id_halt) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DRAIN_CYCLES;
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = drain_cnt_q - 2'd1;
        if (drain_cnt_q == 2'd1) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        // Counter keeps running down but rests at zero instead of wrapping.
        if (drain_cnt_q != 2'd0) begin
          drain_cnt_d = drain_cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (raw_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= 2'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl. Inputs change 1ns after the rising
// edge; outputs are sampled on the falling edge.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_valid = 1'b0;
  logic [2:0]  id_rs = '0;
  logic        id_rs_used = 1'b0;
  logic [2:0]  id_rt = '0;
  logic        id_rt_used = 1'b0;
  logic [2:0]  id_rd = '0;
  logic        id_regwrt = 1'b0;
  logic        id_halt = 1'b0;
  logic        ex_redirect = 1'b0;
  logic        pc_stall, ifid_stall, idex_bubble, ifid_flush, halted;
  logic [15:0] stall_cnt;
  logic [4:0]  ctrl;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rs_used  (id_rs_used),
    .id_rt       (id_rt),
    .id_rt_used  (id_rt_used),
    .id_rd       (id_rd),
    .id_regwrt   (id_regwrt),
    .id_halt     (id_halt),
    .ex_redirect (ex_redirect),
    .pc_stall    (pc_stall),
    .ifid_stall  (ifid_stall),
    .idex_bubble (idex_bubble),
    .ifid_flush  (ifid_flush),
    .halted      (halted),
    .stall_cnt   (stall_cnt)
  );

  // {pc_stall, ifid_stall, idex_bubble, ifid_flush, halted}
  assign ctrl = {pc_stall, ifid_stall, idex_bubble, ifid_flush, halted};

  // One pipeline cycle: apply inputs after the rising edge, return at the
  // falling edge so the caller can sample.
  task automatic cyc(input logic v, input logic [2:0] rs, input logic rsu,
                     input logic [2:0] rt, input logic rtu, input logic [2:0] rd,
                     input logic rw, input logic hlt, input logic redir);
    @(posedge clk);
    #1;
    id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_rd = rd; id_regwrt = rw; id_halt = hlt; ex_redirect = redir;
    #4;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Leaves the next rising edge as the start of cycle 0.
  task automatic do_reset();
    rst = 1'b0;
    id_valid = 0; id_rs = 0; id_rs_used = 0; id_rt = 0; id_rt_used = 0;
    id_rd = 0; id_regwrt = 0; id_halt = 0; ex_redirect = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    id_valid = 1; id_rs = 3; id_rs_used = 1; ex_redirect = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (ctrl !== 5'b00000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want %b", ctrl, 5'b00000);
    end else $display("reset_ctrl ok ctrl=%b", ctrl);
    n_cmp++;
    if (stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
    end else $display("reset_stall_cnt ok");
  endtask

  task automatic test_load_use();
    logic [4:0] exp_ctrl [4] = '{5'b00000, 5'b11100, 5'b11100, 5'b00000};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      if (c == 0) cyc(1, 0, 0, 0, 0, 3, 1, 0, 0);
      else        cyc(1, 3, 1, 0, 0, 4, 1, 0, 0);
      n_cmp++;
      if (ctrl !== exp_ctrl[c]) begin
        n_fail++; $display("FAIL load_use_c%0d: got %b want %b", c, ctrl, exp_ctrl[c]);
      end else $display("load_use_c%0d ok ctrl=%b", c, ctrl);
    end
    n_cmp++;
    if (stall_cnt !== 16'd2) begin
      n_fail++; $display("FAIL load_use_cnt: got %0d want 2", stall_cnt);
    end else $display("load_use_cnt ok cnt=%0d", stall_cnt);
    idle(1);
    n_cmp++;
    if (stall_cnt !== 16'd2) begin
      n_fail++; $display("FAIL load_use_cnt_hold: got %0d want 2", stall_cnt);
    end else $display("load_use_cnt_hold ok");
  endtask

  task automatic test_one_apart();
    logic [4:0] exp_ctrl [4] = '{5'b00000, 5'b00000, 5'b11100, 5'b00000};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      case (c)
        0:       cyc(1, 0, 0, 0, 0, 5, 1, 0, 0);
        1:       cyc(1, 2, 1, 6, 1, 1, 1, 0, 0);
        default: cyc(1, 0, 0, 5, 1, 2, 1, 0, 0);
      endcase
      n_cmp++;
      if (ctrl !== exp_ctrl[c]) begin
        n_fail++; $display("FAIL one_apart_c%0d: got %b want %b", c, ctrl, exp_ctrl[c]);
      end else $display("one_apart_c%0d ok ctrl=%b", c, ctrl);
    end
    n_cmp++;
    if (stall_cnt !== 16'd1) begin
      n_fail++; $display("FAIL one_apart_cnt: got %0d want 1", stall_cnt);
    end else $display("one_apart_cnt ok cnt=%0d", stall_cnt);
  endtask

  // Reader of r1 from MEM and r2 from EX: worst case, two stall cycles.
  task automatic test_max_stall();
    logic [4:0] exp_ctrl [5] = '{5'b00000, 5'b00000, 5'b11100, 5'b11100, 5'b00000};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      case (c)
        0:       cyc(1, 0, 0, 0, 0, 1, 1, 0, 0);
        1:       cyc(1, 0, 0, 0, 0, 2, 1, 0, 0);
        default: cyc(1, 1, 1, 2, 1, 7, 1, 0, 0);
      endcase
      n_cmp++;
      if (ctrl !== exp_ctrl[c]) begin
        n_fail++; $display("FAIL max_stall_c%0d: got %b want %b", c, ctrl, exp_ctrl[c]);
      end else $display("max_stall_c%0d ok ctrl=%b", c, ctrl);
    end
    n_cmp++;
    if (stall_cnt !== 16'd2) begin
      n_fail++; $display("FAIL max_stall_cnt: got %0d want 2", stall_cnt);
    end else $display("max_stall_cnt ok cnt=%0d", stall_cnt);
  endtask

  task automatic test_redirect();
    logic [4:0] exp_ctrl [4] = '{5'b00000, 5'b00110, 5'b00000, 5'b00000};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: cyc(1, 0, 0, 0, 0, 2, 1, 0, 0);
        1: cyc(1, 2, 1, 0, 0, 6, 1, 0, 1);   // raw + redirect, squashed writer of r6
        2: cyc(1, 6, 1, 0, 0, 0, 0, 0, 0);   // r6 must not be pending
        default: cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      n_cmp++;
      if (ctrl !== exp_ctrl[c]) begin
        n_fail++; $display("FAIL redirect_c%0d: got %b want %b", c, ctrl, exp_ctrl[c]);
      end else $display("redirect_c%0d ok ctrl=%b", c, ctrl);
    end
    n_cmp++;
    if (stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL redirect_cnt: got %0d want 0", stall_cnt);
    end else $display("redirect_cnt ok cnt=%0d", stall_cnt);
  endtask

  task automatic test_false_hazard();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);   // writes r0
        1: cyc(1, 0, 0, 1, 0, 3, 1, 0, 0);   // names r0 but rs_used=0
        2: cyc(1, 0, 0, 0, 0, 7, 0, 0, 0);   // rd=7, regwrt=0
        3: cyc(1, 7, 1, 0, 0, 1, 0, 0, 0);   // reads r7
        4: cyc(1, 0, 0, 7, 1, 4, 1, 0, 0);   // reads r7, writes r4
        5: cyc(0, 4, 1, 4, 1, 0, 0, 0, 0);   // not valid
        default: cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      n_cmp++;
      if (ctrl !== 5'b00000) begin
        n_fail++; $display("FAIL false_hazard_c%0d: got %b want %b", c, ctrl, 5'b00000);
      end else $display("false_hazard_c%0d ok ctrl=%b", c, ctrl);
    end
    n_cmp++;
    if (stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL false_hazard_cnt: got %0d want 0", stall_cnt);
    end else $display("false_hazard_cnt ok");
  endtask

  task automatic test_halt();
    logic [4:0] exp_ctrl [7] = '{5'b00000, 5'b11100, 5'b11100, 5'b11100,
                                 5'b11101, 5'b11101, 5'b11101};
    do_reset();
    idle(10);
    for (int c = 10; c < 17; c++) begin
      case (c)
        10: cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
        12: cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);  // redirect ignored in DRAIN
        15: cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);  // and in HALTED
        default: cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      n_cmp++;
      if (ctrl !== exp_ctrl[c-10]) begin
        n_fail++; $display("FAIL halt_c%0d: got %b want %b", c, ctrl, exp_ctrl[c-10]);
      end else $display("halt_c%0d ok ctrl=%b", c, ctrl);
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    cyc(1, 0, 0, 0, 0, 3, 1, 0, 0);
    cyc(1, 3, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 3, 1, 0, 0, 0, 0, 0, 0);
    idle(7);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);          // cycle 10: HALT
    idle(2);                                 // now at cycle 12, DRAIN
    n_cmp++;
    if ({ctrl, stall_cnt} !== {5'b11100, 16'd2}) begin
      n_fail++; $display("FAIL mid_drain_pre: got %b/%0d want 11100/2", ctrl, stall_cnt);
    end else $display("mid_drain_pre ok ctrl=%b cnt=%0d", ctrl, stall_cnt);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({ctrl, stall_cnt} !== {5'b00000, 16'd0}) begin
      n_fail++; $display("FAIL mid_drain_async: got %b/%0d want 00000/0", ctrl, stall_cnt);
    end else $display("mid_drain_async ok");
    @(negedge clk);
    rst = 1'b1;
    cyc(1, 3, 1, 0, 0, 0, 0, 0, 0);          // RUN, no stale r3 hazard
    n_cmp++;
    if (ctrl !== 5'b00000) begin
      n_fail++; $display("FAIL mid_drain_run: got %b want 00000", ctrl);
    end else $display("mid_drain_run ok");
    // Drive into HALTED, then reset again.
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(4);
    n_cmp++;
    if (ctrl !== 5'b11101) begin
      n_fail++; $display("FAIL halted_pre: got %b want 11101", ctrl);
    end else $display("halted_pre ok");
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ctrl !== 5'b00000) begin
      n_fail++; $display("FAIL halted_async: got %b want 00000", ctrl);
    end else $display("halted_async ok");
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_one_apart();
    test_max_stall();
    test_redirect();
    test_false_hazard();
    test_halt();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
